// File: rtl/bubble_page_buffer.sv
// Double-buffered bubble page store: the loader fills the write bank while the read bank streams out.
// Optional build macro BUBBLE_PAGE_BUFFER_BLANK_ON_UNDERRUN_EN blanks underrun pages instead of replaying them.
module bubble_page_buffer #(
  parameter int CHANNELS   = 2,
  parameter int ADDR_WIDTH = 11,
  parameter int PAGE_LEN   = 1168
) (
  input  logic                  master_clock,
  input  logic                  master_reset_n,
  input  logic                  load_start,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [CHANNELS-1:0]   wr_data,
  input  logic                  load_done,
  input  logic                  page_start,
  input  logic                  data_out_strobe,
  output logic [CHANNELS-1:0]   bubble_out,
  output logic                  bank_ready,
  output logic                  loading,
  output logic                  read_bank,
  output logic                  underrun
);

  localparam int                DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PAGE_END = (ADDR_WIDTH + 1)'(PAGE_LEN);
`ifdef BUBBLE_PAGE_BUFFER_BLANK_ON_UNDERRUN_EN
  localparam logic BLANK_ON_UNDERRUN = 1'b1;
`else
  localparam logic BLANK_ON_UNDERRUN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2
  } wr_state_e;

  // Both banks share one array; the top index bit selects the bank.
  logic [CHANNELS-1:0] mem_q [0:2*DEPTH-1];

  wr_state_e           state_q, state_d;
  logic                read_bank_q, read_bank_d;
  logic                read_valid_q, read_valid_d;
  logic                blank_q, blank_d;
  logic                underrun_q, underrun_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [CHANNELS-1:0] bubble_out_q, bubble_out_d;
  logic                bank_ready_q, bank_ready_d;
  logic                loading_q, loading_d;

  logic                done_s;
  logic                swap_s;
  logic                word_live_s;
  logic                wr_accept_s;
  logic [ADDR_WIDTH:0] wr_index_s;
  logic [ADDR_WIDTH:0] rd_index_s;

  // Write-side acceptance: only while filling and only inside the page.
  always_comb begin
    wr_accept_s = (state_q == ST_FILL) && wr_en && ({1'b0, wr_addr} < PAGE_END);
    wr_index_s  = {~read_bank_q, wr_addr};
  end

  // Next-state, swap/underrun handling and read-side output word.
  always_comb begin
    state_d      = state_q;
    read_bank_d  = read_bank_q;
    read_valid_d = read_valid_q;
    blank_d      = blank_q;
    underrun_d   = underrun_q;
    rd_ptr_d     = rd_ptr_q;
    bubble_out_d = bubble_out_q;
    done_s       = (state_q == ST_FILL) && load_done;
    swap_s       = 1'b0;
    word_live_s  = 1'b0;
    rd_index_s   = '0;

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (load_done) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // load_done is folded in first so a same-cycle page_start still swaps.
    swap_s = page_start && ((state_q == ST_READY) || done_s);

    if (page_start) begin
      rd_ptr_d = '0;
      if (swap_s) begin
        state_d      = ST_IDLE;
        read_bank_d  = ~read_bank_q;
        read_valid_d = 1'b1;
        blank_d      = 1'b0;
      end else begin
        underrun_d = 1'b1;
        blank_d    = BLANK_ON_UNDERRUN;
      end
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // A strobe reads through the post-swap bank and pointer.
    word_live_s = (rd_ptr_d < PAGE_END);
    rd_index_s  = {read_bank_d, rd_ptr_d[ADDR_WIDTH-1:0]};
    if (data_out_strobe) begin
      if (read_valid_d && !blank_d && word_live_s) begin
        bubble_out_d = mem_q[rd_index_s];
      end else begin
        bubble_out_d = '0;
      end
      if (word_live_s) begin
        rd_ptr_d = rd_ptr_d + (ADDR_WIDTH + 1)'(1);
      end else begin
        rd_ptr_d = PAGE_END;
      end
    end else begin
      bubble_out_d = bubble_out_q;
    end

    bank_ready_d = (state_d == ST_READY);
    loading_d    = (state_d == ST_FILL);
  end

  // Page memory write port; contents survive reset.
  always_ff @(posedge master_clock) begin
    if (master_reset_n && wr_accept_s) begin
      mem_q[wr_index_s] <= wr_data;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge master_clock) begin
    if (!master_reset_n) begin
      state_q      <= ST_IDLE;
      read_bank_q  <= 1'b0;
      read_valid_q <= 1'b0;
      blank_q      <= 1'b0;
      underrun_q   <= 1'b0;
      rd_ptr_q     <= '0;
      bubble_out_q <= '0;
      bank_ready_q <= 1'b0;
      loading_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_bank_q  <= read_bank_d;
      read_valid_q <= read_valid_d;
      blank_q      <= blank_d;
      underrun_q   <= underrun_d;
      rd_ptr_q     <= rd_ptr_d;
      bubble_out_q <= bubble_out_d;
      bank_ready_q <= bank_ready_d;
      loading_q    <= loading_d;
    end
  end

  assign bubble_out = bubble_out_q;
  assign bank_ready = bank_ready_q;
  assign loading    = loading_q;
  assign read_bank  = read_bank_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_bubble_page_buffer.sv
// Directed bench for bubble_page_buffer with a page-level reference model checked every cycle.
module tb_bubble_page_buffer;

  localparam int CH = 2;
  localparam int AW = 11;
  localparam int PL = 1168;
`ifdef BUBBLE_PAGE_BUFFER_BLANK_ON_UNDERRUN_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [CH-1:0] wr_data = '0;
  logic          load_done = 1'b0;
  logic          page_start = 1'b0;
  logic          strobe = 1'b0;
  logic [CH-1:0] bubble_out;
  logic          bank_ready, loading, read_bank, underrun;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  bubble_page_buffer #(.CHANNELS(CH), .ADDR_WIDTH(AW), .PAGE_LEN(PL)) dut (
    .master_clock(clk), .master_reset_n(rst_n), .load_start(load_start),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .load_done(load_done),
    .page_start(page_start), .data_out_strobe(strobe), .bubble_out(bubble_out),
    .bank_ready(bank_ready), .loading(loading), .read_bank(read_bank), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Reference model: two page images, a "fresh page waiting" flag and a play position.
  logic [CH-1:0] page_img [2][PL];
  int  m_rb, m_ptr;
  bit  m_filling, m_full, m_valid, m_blank, m_under;
  logic [CH-1:0] m_out;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < PL; a++) page_img[b][a] = '0;
  end

  always @(posedge clk) begin
    int  wb;
    bit  do_wr;
    if (!rst_n) begin
      m_rb = 0; m_ptr = 0; m_filling = 0; m_full = 0;
      m_valid = 0; m_blank = 0; m_under = 0; m_out = '0;
    end else begin
      wb    = 1 - m_rb;
      do_wr = m_filling && wr_en && (int'(wr_addr) < PL);
      if (m_filling && load_done) begin
        m_filling = 0; m_full = 1;
      end else if (load_start && !m_full) begin
        m_filling = 1;
      end
      if (page_start) begin
        m_ptr = 0;
        if (m_full) begin
          m_rb = 1 - m_rb; m_full = 0; m_filling = 0; m_valid = 1; m_blank = 0;
        end else begin
          m_under = 1; m_blank = BLANK;
        end
      end
      if (strobe) begin
        m_out = (m_valid && !m_blank && m_ptr < PL) ? page_img[m_rb][m_ptr] : '0;
        if (m_ptr < PL) m_ptr++;
      end
      if (do_wr) page_img[wb][wr_addr] = wr_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("bubble_out", 32'(bubble_out), 32'(m_out));
      chk("bank_ready", 32'(bank_ready), 32'(m_full));
      chk("loading", 32'(loading), 32'(m_filling));
      chk("read_bank", 32'(read_bank), 32'(m_rb));
      chk("underrun", 32'(underrun), 32'(m_under));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    load_start = 1'b0; wr_en = 1'b0; load_done = 1'b0;
    page_start = 1'b0; strobe = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      strobe = 1'b1;
      cyc();
    end
  endtask

  // Fill addresses 0..PL-2 (or PL-1) with pattern pat.
  task automatic fill(input int pat, input int count);
    load_start = 1'b1;
    cyc();
    for (int a = 0; a < count; a++) begin
      wr_en = 1'b1;
      wr_addr = AW'(a);
      wr_data = CH'(a) ^ CH'(pat);
      if (a == 5) load_start = 1'b1;
      cyc();
    end
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    chk("rst_bubble_out", 32'(bubble_out), 32'd0);
    chk("rst_read_bank", 32'(read_bank), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);

    // Underrun straight out of reset: no valid bank, zeros in both builds.
    page_start = 1'b1;
    cyc();
    chk("ur0_flag", 32'(underrun), 32'd1);
    chk("ur0_bank", 32'(read_bank), 32'd0);
    strobes(3);
    chk("ur0_data", 32'(bubble_out), 32'd0);

    // Basic load and stream into bank 1.
    do_reset();
    fill(0, PL);
    wr_en = 1'b1; wr_addr = AW'(PL); wr_data = 2'd3;
    cyc();
    load_done = 1'b1;
    cyc();
    chk("ready_set", 32'(bank_ready), 32'd1);
    load_start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 2'd3;
    cyc();
    chk("ready_ignores_start", 32'(bank_ready), 32'd1);
    page_start = 1'b1;
    cyc();
    chk("swap_bank", 32'(read_bank), 32'd1);
    chk("swap_ready_clr", 32'(bank_ready), 32'd0);
    strobes(1); chk("word0", 32'(bubble_out), 32'd0);
    strobes(1); chk("word1", 32'(bubble_out), 32'd1);
    strobes(1); chk("word2", 32'(bubble_out), 32'd2);
    cyc();      chk("hold", 32'(bubble_out), 32'd2);
    strobes(PL - 3); chk("word_last", 32'(bubble_out), 32'd3);
    strobes(1); chk("overrun1", 32'(bubble_out), 32'd0);
    strobes(1); chk("overrun2", 32'(bubble_out), 32'd0);

    // Second page_start with nothing loaded: replay or blank.
    page_start = 1'b1;
    cyc();
    chk("ur1_flag", 32'(underrun), 32'd1);
    chk("ur1_bank", 32'(read_bank), 32'd1);
    strobes(2);
    chk("ur1_word1", 32'(bubble_out), BLANK ? 32'd0 : 32'd1);
    strobes(2);
    chk("ur1_word3", 32'(bubble_out), BLANK ? 32'd0 : 32'd3);

    // Same-cycle last write + load_done + page_start + strobe.
    do_reset();
    fill(3, PL - 1);
    wr_en = 1'b1; wr_addr = AW'(PL - 1); wr_data = 2'd2;
    load_done = 1'b1; page_start = 1'b1; strobe = 1'b1;
    cyc();
    chk("sc_bank", 32'(read_bank), 32'd1);
    chk("sc_underrun", 32'(underrun), 32'd0);
    chk("sc_word0", 32'(bubble_out), 32'd3);
    strobes(1); chk("sc_word1", 32'(bubble_out), 32'd2);
    strobes(PL - 2); chk("sc_lastwr", 32'(bubble_out), 32'd2);

    // Reset in the middle of a fill.
    load_start = 1'b1;
    cyc();
    wr_en = 1'b1; wr_addr = '0; wr_data = 2'd1;
    cyc();
    chk("fill_loading", 32'(loading), 32'd1);
    do_reset();
    chk("mid_rst_loading", 32'(loading), 32'd0);
    chk("mid_rst_ready", 32'(bank_ready), 32'd0);
    chk("mid_rst_bank", 32'(read_bank), 32'd0);
    page_start = 1'b1; strobe = 1'b1;
    cyc();
    chk("mid_rst_ur", 32'(underrun), 32'd1);
    chk("mid_rst_data", 32'(bubble_out), 32'd0);
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bubble_page_buffer.md
# bubble_page_buffer

Parametrised, double-buffered page store between the SPI flash loader and the bubble output interface of the bubble drive emulator. The loader fills one bank while the interface streams the other. A bank swap happens only at a page boundary. The two fixed odd/even data lines are generalised to `CHANNELS` parallel bubble outputs. Underrun detection and a selectable underrun policy are included.

## Interface
Parameters:
- `CHANNELS`, 2, bits per buffer word; one bit per bubble output line.
- `ADDR_WIDTH`, 11, bank address width; each bank holds 2^`ADDR_WIDTH` words.
- `PAGE_LEN`, 1168, words per page; must satisfy 1 ≤ `PAGE_LEN` ≤ 2^`ADDR_WIDTH`.

Ports:
- `master_clock`  in  1  sole clock; all logic on its rising edge.
- `master_reset_n`  in  1  synchronous, active-low reset.
- `load_start`  in  1  loader pulse: begin filling the write bank.
- `wr_en`  in  1  loader write strobe.
- `wr_addr`  in  `ADDR_WIDTH`  write word address.
- `wr_data`  in  `CHANNELS`  write word.
- `load_done`  in  1  loader pulse: write bank complete.
- `page_start`  in  1  interface pulse: new page begins; swap point.
- `data_out_strobe`  in  1  interface pulse: advance one bit position.
- `bubble_out`  out  `CHANNELS`  current bit of each channel.
- `bank_ready`  out  1  write bank full, awaiting swap.
- `loading`  out  1  write bank being filled.
- `read_bank`  out  1  index of bank being streamed.
- `underrun`  out  1  sticky; a page started with no fresh bank.

## Operation
- There are two banks. The write bank is always `~read_bank`.
- Write-side FSM states: IDLE, FILL, READY.
  - IDLE → FILL on `load_start`.
  - FILL → READY on `load_done`.
  - READY → IDLE on a swap.
  - `load_start` in FILL restarts the fill and stays in FILL.
  - `load_start` in READY is ignored.
- `loading` = (state == FILL). `bank_ready` = (state == READY).
- Writes are accepted only in FILL, and only when `wr_addr` < `PAGE_LEN`. All other writes are dropped silently.
- On `page_start`:
  - If READY: toggle `read_bank`, set `read_valid`, clear the read pointer, go to IDLE.
  - If not READY: set `underrun`, clear the read pointer, keep `read_bank`. The underrun policy is defined under Configuration.
- Read pointer behaviour:
  - `data_out_strobe` loads the word at the read pointer into `bubble_out`, then increments the pointer.
  - The pointer saturates at `PAGE_LEN`.
  - A strobe with pointer == `PAGE_LEN` outputs all zeros.
- `read_valid` is cleared by reset. While it is 0, `bubble_out` is all zeros on every strobe.
- `underrun` clears only on reset.
- Reset mid-operation clears all state and outputs. Memory contents are not cleared, but they are unreachable until a fresh load and swap.

## Timing
- Reset values of all outputs are 0: `bubble_out`, `bank_ready`, `loading`, `read_bank`, `underrun`. The FSM resets to IDLE. The read pointer resets to 0.
- Read latency: `bubble_out` updates on the edge after `data_out_strobe` is sampled (1 cycle). It holds until the next strobe.
- Status latency: `bank_ready`, `loading`, `read_bank` and `underrun` update 1 cycle after the causing input.
- A write is visible to reads no earlier than the swap that follows it.
- Simultaneous-event rules:
  - `load_done` and `page_start` in the same cycle: `load_done` is evaluated first, so the swap occurs and `underrun` is not set.
  - `page_start` and `data_out_strobe` in the same cycle: the strobe reads word 0 of the resulting read bank, and the pointer becomes 1.
  - `wr_en` and `load_done` in the same cycle: the write is accepted.
- Back-to-back strobes on consecutive cycles are supported at full rate.

## Configuration
- Macro: `BUBBLE_PAGE_BUFFER_BLANK_ON_UNDERRUN_EN`.
- Undefined: on underrun, the current read bank is replayed from word 0. Data output is unchanged apart from the pointer reset.
- Defined: on underrun, every strobe of that page outputs all zeros, so the page reads as bubble-free. Normal output resumes after the next successful swap.
- `underrun` flag behaviour is identical in both builds.

## Test plan
- Reset then `page_start` with no load → `underrun`=1, `read_bank`=0, and every strobe gives `bubble_out`=0 in both builds.
- Basic load and stream: `load_start`; write `wr_data`=addr[1:0] to addrs 0..1167; `load_done` → `bank_ready`=1. Then `page_start` → `read_bank`=1, `bank_ready`=0. 1168 strobes give 0,1,2,3,… one cycle after each strobe.
- Overrun: 1170 strobes after the page above → strobes 1169 and 1170 output 0, and the pointer holds at 1168.
- Underrun policy: load page A, swap, then `page_start` again with no new load.
  - Macro undefined → page A replays from word 0.
  - Macro defined → all zeros.
  - Both builds → `underrun`=1.
- Same-cycle `load_done`+`page_start` → swap occurs, `underrun` stays 0, and a strobe in that cycle also reads word 0. Separately, `master_reset_n`=0 mid-FILL → `loading`=0, state IDLE.
